// File: rtl/asym_fifo_if.sv
// rtl/asym_fifo_if.sv - write/read handshake bundle for asym_fifo
interface asym_fifo_if #(
  parameter int W_IN  = 16,
  parameter int W_OUT = 4,
  parameter int DEPTH = 64
);
  localparam int FW = $clog2(DEPTH + 1);

  logic             s_valid;
  logic             s_ready;
  logic [W_IN-1:0]  s_data;
  logic             m_valid;
  logic             m_ready;
  logic [W_OUT-1:0] m_data;
  logic [FW-1:0]    fill;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, fill
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, fill
  );
endinterface

// File: rtl/asym_fifo.sv
// rtl/asym_fifo.sv - single-clock asymmetric-width FIFO with registered output
module asym_fifo #(
  parameter int W_IN  = 16,
  parameter int W_OUT = 4,
  parameter int DEPTH = 64
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  asym_fifo_if.slave bus
);
  localparam int MINW  = (W_IN < W_OUT) ? W_IN : W_OUT;
  localparam int MAXW  = (W_IN < W_OUT) ? W_OUT : W_IN;
  localparam int RATIO = MAXW / MINW;
  localparam int RI    = W_IN / MINW;
  localparam int RO    = W_OUT / MINW;
  localparam int AW    = $clog2(DEPTH);
  localparam int FW    = $clog2(DEPTH + 1);

  generate
    if ((MAXW % MINW) != 0 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
      $error("asym_fifo: W_IN/W_OUT must differ by a power-of-two ratio");
    end
    if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 2 * RATIO) begin : g_bad_depth
      $error("asym_fifo: DEPTH must be a power of two and at least 2*ratio");
    end
  endgenerate

  logic [MINW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             m_valid_q, m_valid_d;
  logic [W_OUT-1:0] m_data_q, m_data_d;
  logic             s_ready;
  logic             wr;
  logic             pop;

  // s_ready looks only at registered fill, so a same-cycle pop never frees space early
  assign s_ready = (fill_q <= FW'(DEPTH - RI));
  assign wr      = bus.s_valid & s_ready;
  assign pop     = (fill_q >= FW'(RO)) & (~m_valid_q | bus.m_ready);

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    fill_d    = fill_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (clr) begin
      wptr_d    = '0;
      rptr_d    = '0;
      fill_d    = '0;
      m_valid_d = 1'b0;
    end else begin
      if (wr) begin
        wptr_d = wptr_q + AW'(RI);
      end
      if (pop) begin
        rptr_d    = rptr_q + AW'(RO);
        m_valid_d = 1'b1;
        for (int j = 0; j < RO; j++) begin
          m_data_d[j*MINW +: MINW] = mem_q[rptr_q + AW'(j)];
        end
      end else if (m_valid_q & bus.m_ready) begin
        m_valid_d = 1'b0;
      end
      fill_d = fill_q + (wr ? FW'(RI) : FW'(0)) - (pop ? FW'(RO) : FW'(0));
    end
  end

  // Pointers stay aligned to RI, so a wide write never crosses the wrap point
  always_ff @(posedge clk) begin
    if (wr & ~clr) begin
      for (int i = 0; i < RI; i++) begin
        mem_q[wptr_q + AW'(i)] <= bus.s_data[i*MINW +: MINW];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      fill_q    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      fill_q    <= fill_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.fill    = fill_q;
endmodule
